// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline-register slice: state encoding and word widths.
package pipe_pkg;

  localparam int WORD_WIDTH = 64;
  localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;

  // Stage occupancy states; the encoding doubles as the entry count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/pipe_entry.sv
// One held pipeline entry: valid bit, control bundle and payload.
// Priority is rst > clr_i > load_i. Clear always zeroes valid and control;
// the payload is zeroed on clear only when CLR_DATA is set, but always on reset.
module pipe_entry import pipe_pkg::*; #(
  parameter int DATA_W   = WORD_WIDTH,
  parameter int CTRL_W   = 16,
  parameter int CLR_DATA = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  // Entry register: reset, clear to a bubble, or capture a new entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      if (CLR_DATA != 0) data_q <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register between core stages.
// Handshake: an entry moves upstream->stage when in_valid & in_ready (acc) and
// stage->downstream when out_valid & out_ready (rel); in_valid never waits on in_ready.
// With SKID=1 a second entry absorbs the cycle of latency on in_ready, which is a flop.
module pipe_stage_reg import pipe_pkg::*; #(
  parameter int DATA_W   = WORD_WIDTH,
  parameter int CTRL_W   = 16,
  parameter int SKID     = 1,
  parameter int CLR_DATA = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        level
);

  logic [1:0]        state_q, state_d;
  logic              in_ready_q;
  logic              acc, rel;
  logic              main_load, main_clr, main_sel_skid;
  logic              skid_load, skid_clr;
  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_d;
  logic [DATA_W-1:0] main_data, skid_data, main_data_d;

  assign acc = in_valid & in_ready;
  assign rel = out_valid & out_ready;

  // Next-state and entry-control decode; flush overrides any transfer this cycle.
  always_comb begin
    state_d       = state_q;
    main_load     = 1'b0;
    main_clr      = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    skid_clr      = 1'b0;
    if (flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d   = ST_ONE;
            main_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (acc && !rel) begin
            // Only reachable with a skid entry; without one, acc implies rel here.
            if (SKID != 0) begin
              state_d   = ST_TWO;
              skid_load = 1'b1;
            end
          end else if (acc && rel) begin
            main_load = 1'b1;
          end else if (rel) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
          end
        end
        ST_TWO: begin
          if (rel) begin
            state_d       = ST_ONE;
            main_load     = 1'b1;
            main_sel_skid = 1'b1;
            skid_clr      = 1'b1;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  // State register and registered in_ready (high whenever the next state leaves room).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  // The main entry refills from the skid when draining TWO, otherwise from upstream.
  assign main_ctrl_d = main_sel_skid ? skid_ctrl : in_ctrl;
  assign main_data_d = main_sel_skid ? skid_data : in_data;

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLR_DATA(CLR_DATA)) u_main (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (main_clr),
    .load_i  (main_load),
    .ctrl_i  (main_ctrl_d),
    .data_i  (main_data_d),
    .valid_o (main_valid),
    .ctrl_o  (main_ctrl),
    .data_o  (main_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLR_DATA(CLR_DATA)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (skid_clr),
        .load_i  (skid_load),
        .ctrl_i  (in_ctrl),
        .data_i  (in_data),
        .valid_o (skid_valid),
        .ctrl_o  (skid_ctrl),
        .data_o  (skid_data)
      );
      // Reset forces in_ready low in its own cycle; the flop is already 1 for the next.
      assign in_ready = ~rst & in_ready_q;
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_ctrl  = '0;
      assign skid_data  = '0;
      assign in_ready   = ~rst & (~main_valid | out_ready);
    end
  endgenerate

  // Control is masked on a bubble so downstream never sees stale enables.
  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl & {CTRL_W{main_valid}};
  assign out_data  = main_data;
  assign level     = state_q;

endmodule
